// File: rtl/prog_loader.sv
// Boot-time program loader: turns a length-prefixed byte stream into big-endian instruction words.
// Optional trailing XOR checksum byte is enabled with `define PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W    = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  in_data_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  output logic        core_run_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [15:0] words_loaded_o
);

  localparam logic [31:0] Capacity = 32'(1) << ADDR_W;

`ifdef PROG_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {StIdle, StLenHi, StLenLo, StData, StChk, StDone, StError} state_e;
`else
  typedef enum logic [2:0] {StIdle, StLenHi, StLenLo, StData, StDone, StError} state_e;
`endif

  state_e      state_q, state_d;
  logic [15:0] len_q, len_d;
  logic [15:0] cnt_q, cnt_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] word_q, word_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]  csum_q, csum_d;
`endif

  logic        accept;
  logic [15:0] len_full;
  state_e      st_after_data;

`ifdef PROG_LOADER_CHECKSUM_EN
  assign st_after_data = StChk;
  assign in_ready_o    = (state_q == StLenHi) || (state_q == StLenLo) ||
                         (state_q == StData)  || (state_q == StChk);
`else
  assign st_after_data = StDone;
  assign in_ready_o    = (state_q == StLenHi) || (state_q == StLenLo) || (state_q == StData);
`endif

  assign accept   = in_valid_i && in_ready_o;
  assign len_full = {len_q[15:8], in_data_i};

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    word_d  = word_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    csum_d  = csum_q;
    if (accept && state_q != StChk) begin
      csum_d = csum_q ^ in_data_i;
    end
`endif

    unique case (state_q)
      StIdle, StDone, StError: begin
        if (start_i) begin
          state_d = StLenHi;
          cnt_d   = '0;
          idx_d   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
          csum_d  = '0;
`endif
        end
      end
      StLenHi: begin
        if (accept) begin
          len_d[15:8] = in_data_i;
          state_d     = StLenLo;
        end
      end
      StLenLo: begin
        if (accept) begin
          len_d[7:0] = in_data_i;
          if (32'(len_full) > Capacity) begin
            state_d = StError;
          end else if (len_full == 16'd0) begin
            state_d = st_after_data;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (accept) begin
          word_d = {word_q[15:0], in_data_i};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            // Word is registered here; the write strobe appears the following cycle.
            we_d    = 1'b1;
            addr_d  = BASE_ADDR + {14'd0, cnt_q, 2'b00};
            wdata_d = {word_q, in_data_i};
            cnt_d   = cnt_q + 16'd1;
            if (cnt_q + 16'd1 == len_q) begin
              state_d = st_after_data;
            end
          end
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      StChk: begin
        if (accept) begin
          state_d = (in_data_i == csum_q) ? StDone : StError;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
`ifdef PROG_LOADER_CHECKSUM_EN
      csum_q  <= csum_d;
`endif
    end
  end

  assign mem_we_o       = we_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;
  assign words_loaded_o = cnt_q;
  assign done_o         = (state_q == StDone);
  assign error_o        = (state_q == StError);
  assign core_run_o     = (state_q == StDone);
  assign busy_o         = in_ready_o;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, gapped streams, oversize length, checksum and mid-session reset.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        core_run;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] words_loaded;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] wr_addr[$];
  logic [31:0] wr_data[$];

  logic [7:0] stream [10] = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                               8'h8C, 8'h09, 8'h00, 8'h04};
  logic [7:0] csum;

  always #5 clk = ~clk;

  prog_loader dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .in_data_i      (in_data),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .mem_we_o       (mem_we),
    .mem_addr_o     (mem_addr),
    .mem_wdata_o    (mem_wdata),
    .core_run_o     (core_run),
    .busy_o         (busy),
    .done_o         (done),
    .error_o        (error),
    .words_loaded_o (words_loaded)
  );

  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input int gap);
    int k;
    repeat (gap) @(negedge clk);
    @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    for (k = 0; k < 20 && !in_ready; k++) @(negedge clk);
    if (!in_ready) begin
      n_cmp++;
      n_err++;
      $error("FAIL accept_timeout: observed in_ready=0 expected 1 for byte %h", b);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1 in_valid = 1'b0;
    end
  endtask

  task automatic send_stream(input int gap, input logic [7:0] chk_byte);
    for (int i = 0; i < 10; i++) send(stream[i], gap);
`ifdef PROG_LOADER_CHECKSUM_EN
    send(chk_byte, gap);
`else
    if (chk_byte == 8'h00) ; // checksum byte unused without the checksum stage
`endif
  endtask

  task automatic check_two_writes(input string tag);
    chk({tag, "_nwr"}, wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      chk({tag, "_a0"}, wr_addr[0], 32'h0000_0000);
      chk({tag, "_d0"}, wr_data[0], 32'h2008_0005);
      chk({tag, "_a1"}, wr_addr[1], 32'h0000_0004);
      chk({tag, "_d1"}, wr_data[1], 32'h8C09_0004);
    end
  endtask

  initial begin
    csum = 8'h00;
    for (int i = 0; i < 10; i++) csum = csum ^ stream[i];
    rst_n = 1'b0; start = 1'b0; in_data = 8'h00; in_valid = 1'b0;

    // 1: reset
    #12;
    chk("rst_ready", in_ready, 0);
    chk("rst_run", core_run, 0);
    chk("rst_we", mem_we, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready", in_ready, 0);
    chk("idle_busy", busy, 0);
    chk("idle_done", done, 0);
    chk("idle_err", error, 0);
    chk("idle_run", core_run, 0);
    chk("idle_words", words_loaded, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_wdata", mem_wdata, 0);

    // 2: back-to-back stream
    pulse_start();
    chk("s2_busy", busy, 1);
    chk("s2_ready", in_ready, 1);
    send_stream(0, csum);
    repeat (2) @(negedge clk);
    check_two_writes("s2");
    chk("s2_words", words_loaded, 2);
    chk("s2_done", done, 1);
    chk("s2_run", core_run, 1);
    chk("s2_busy_end", busy, 0);
    chk("s2_ready_end", in_ready, 0);
    chk("s2_hold_addr", mem_addr, 32'h4);
    chk("s2_hold_wdata", mem_wdata, 32'h8C09_0004);

    // 3: restart from DONE, 3-cycle gaps between bytes
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    chk("s3_run_drop", core_run, 0);
    chk("s3_done_clr", done, 0);
    chk("s3_words_clr", words_loaded, 0);
    send_stream(3, csum);
    repeat (2) @(negedge clk);
    check_two_writes("s3");
    chk("s3_words", words_loaded, 2);
    chk("s3_done", done, 1);
    chk("s3_run", core_run, 1);

    // 4: N = 257 exceeds 2^8 words
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send(8'h01, 0);
    send(8'h01, 0);
    repeat (2) @(negedge clk);
    chk("s4_err", error, 1);
    chk("s4_run", core_run, 0);
    chk("s4_nwr", wr_addr.size(), 0);
    chk("s4_ready", in_ready, 0);
    pulse_start();
    chk("s4_err_clr", error, 0);
    send_stream(0, csum);
    repeat (2) @(negedge clk);
    chk("s4_rec_done", done, 1);
    chk("s4_rec_run", core_run, 1);
    check_two_writes("s4_rec");

`ifdef PROG_LOADER_CHECKSUM_EN
    // 5: bad checksum
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_stream(0, 8'hFF);
    repeat (2) @(negedge clk);
    check_two_writes("s5");
    chk("s5_err", error, 1);
    chk("s5_run", core_run, 0);
    chk("s5_done", done, 0);
`endif

    // 6: reset after 6 bytes
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    for (int i = 0; i < 6; i++) send(stream[i], 0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s6_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) begin
      chk("s6_a0", wr_addr[0], 32'h0);
      chk("s6_d0", wr_data[0], 32'h2008_0005);
    end
    chk("s6_run", core_run, 0);
    chk("s6_busy", busy, 0);
    chk("s6_ready", in_ready, 0);
    chk("s6_words", words_loaded, 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("s6_idle_ready", in_ready, 0);
    chk("s6_idle_run", core_run, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
